// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC bus responder.
// Holds the register map addresses, control bit indices and the BCD helper
// functions used by the clock/timer datapath.
package rtc_pkg;

    // Register map
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_SEC    = 8'h21;
    localparam logic [7:0] ADDR_MIN    = 8'h22;
    localparam logic [7:0] ADDR_HOUR   = 8'h23;
    localparam logic [7:0] ADDR_DAY    = 8'h24;
    localparam logic [7:0] ADDR_MONTH  = 8'h25;
    localparam logic [7:0] ADDR_YEAR   = 8'h26;
    localparam logic [7:0] ADDR_TSEC   = 8'h41;
    localparam logic [7:0] ADDR_TMIN   = 8'h42;
    localparam logic [7:0] ADDR_THOUR  = 8'h43;

    // Control register bit indices
    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_HALT     = 2;

    // BCD increment: at/above max wraps to min, a low nibble of 9 carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                           input logic [7:0] min_v,
                                           input logic [7:0] max_v);
        logic [7:0] r;
        if (value >= max_v) begin
            r = min_v;
        end else if (value[3:0] >= 4'd9) begin
            r = {value[7:4] + 4'd1, 4'd0};
        end else begin
            r = value + 8'd1;
        end
        return r;
    endfunction

    // BCD decrement: 00 wraps to max, a low nibble of 0 borrows from tens.
    function automatic logic [7:0] bcd_dec(input logic [7:0] value,
                                           input logic [7:0] max_v);
        logic [7:0] r;
        if (value == 8'h00) begin
            r = max_v;
        end else if (value[3:0] == 4'd0) begin
            r = {value[7:4] - 4'd1, 4'd9};
        end else begin
            r = value - 8'd1;
        end
        return r;
    endfunction

    // Last day of the month in BCD; leap years follow the binary value of the BCD year.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        logic [7:0] year_bin;
        logic [7:0] r;
        year_bin = 8'({4'd0, year[7:4]} * 8'd10) + {4'd0, year[3:0]};
        case (month)
            8'h02:                      r = (year_bin[1:0] == 2'b00) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rtc_bus_responder_if.sv
// rtc_bus_responder_if: multiplexed address/data bus between the RTC controller
// (master) and the RTC responder (slave).
//   AD       address(0)/data(1) phase select
//   CS/RD/WR active-low chip select, read and write strobes
//   adata_i  bus value from the pad, adata_o/adata_oe read data and pad enable
//   IRQ      active-high level interrupt
interface rtc_bus_responder_if;
    logic       AD;
    logic       CS;
    logic       RD;
    logic       WR;
    logic [7:0] adata_i;
    logic [7:0] adata_o;
    logic       adata_oe;
    logic       IRQ;

    modport master (output AD, CS, RD, WR, adata_i,
                    input  adata_o, adata_oe, IRQ);
    modport slave  (input  AD, CS, RD, WR, adata_i,
                    output adata_o, adata_oe, IRQ);
endinterface

// File: rtl/rtc_bus_sync.sv
// rtc_bus_sync: two-flop synchronizers for the asynchronous bus pins plus
// WR rising-edge and read-condition detection.
//   Inputs : clock, reset (async active-low), raw ad/cs/rd/wr pins, data_i
//   Outputs: wr_addr_stb / wr_data_stb (1-cycle strobes), rd_active (level),
//            data_s (synchronized bus value)
module rtc_bus_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic       ad_i,
    input  logic       cs_i,
    input  logic       rd_i,
    input  logic       wr_i,
    input  logic [7:0] data_i,
    output logic       wr_addr_stb,
    output logic       wr_data_stb,
    output logic       rd_active,
    output logic [7:0] data_s
);
    logic [1:0] ad_q;
    logic [1:0] cs_q;
    logic [1:0] rd_q;
    logic [1:0] wr_q;
    logic [7:0] data_m_q;
    logic [7:0] data_q;
    logic       wr_prev_q;
    logic       wr_rise_s;

    // Synchronizer chains; strobes reset to their idle-high level so that
    // releasing reset never looks like a WR rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ad_q      <= 2'b00;
            cs_q      <= 2'b11;
            rd_q      <= 2'b11;
            wr_q      <= 2'b11;
            data_m_q  <= 8'h00;
            data_q    <= 8'h00;
            wr_prev_q <= 1'b1;
        end else begin
            ad_q      <= {ad_q[0], ad_i};
            cs_q      <= {cs_q[0], cs_i};
            rd_q      <= {rd_q[0], rd_i};
            wr_q      <= {wr_q[0], wr_i};
            data_m_q  <= data_i;
            data_q    <= data_m_q;
            wr_prev_q <= wr_q[1];
        end
    end

    assign wr_rise_s   = wr_q[1] & ~wr_prev_q;
    assign wr_addr_stb = wr_rise_s & ~cs_q[1] & ~ad_q[1];
    assign wr_data_stb = wr_rise_s & ~cs_q[1] &  ad_q[1];
    assign rd_active   = ~cs_q[1] & ~rd_q[1] & ad_q[1];
    assign data_s      = data_q;

endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: RTC chip model on the multiplexed address/data bus.
// Keeps a BCD date/time and countdown timer, advances once per
// TICKS_PER_SEC clocks and raises IRQ when the enabled timer expires.
//   clock, reset (async active-low), bus (slave side of rtc_bus_responder_if)
module rtc_bus_responder
    import rtc_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    rtc_bus_responder_if.slave   bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 32'd1);

    logic       wr_addr_stb, wr_data_stb, rd_active;
    logic [7:0] data_s;

    rtc_bus_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .ad_i        (bus.AD),
        .cs_i        (bus.CS),
        .rd_i        (bus.RD),
        .wr_i        (bus.WR),
        .data_i      (bus.adata_i),
        .wr_addr_stb (wr_addr_stb),
        .wr_data_stb (wr_data_stb),
        .rd_active   (rd_active),
        .data_s      (data_s)
    );

    logic [7:0]    addr_q, sec_q, min_q, hour_q, day_q, month_q, year_q;
    logic [7:0]    addr_d, sec_d, min_d, hour_d, day_d, month_d, year_d;
    logic [7:0]    tsec_q, tmin_q, thour_q, tsec_d, tmin_d, thour_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          status_q, status_d, pend_q, pend_d, irq_q, oe_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    rdata_q, rd_mux_s, dim_s;
    logic          due_s, c_sec, c_min, c_hour, c_day, c_mon;
    logic          b_sec, b_min, timer_nz_s;
    logic [7:0]    tsec_n, tmin_n, thour_n;

    // Carry chain of the calendar and borrow chain of the countdown timer.
    assign dim_s      = days_in_month(month_q, year_q);
    assign c_sec      = (sec_q >= 8'h59);
    assign c_min      = c_sec & (min_q >= 8'h59);
    assign c_hour     = c_min & (hour_q >= 8'h23);
    assign c_day      = c_hour & (day_q >= dim_s);
    assign c_mon      = c_day & (month_q >= 8'h12);
    assign b_sec      = (tsec_q == 8'h00);
    assign b_min      = b_sec & (tmin_q == 8'h00);
    assign tsec_n     = bcd_dec(tsec_q, 8'h59);
    assign tmin_n     = b_sec ? bcd_dec(tmin_q, 8'h59) : tmin_q;
    assign thour_n    = b_min ? bcd_dec(thour_q, 8'h99) : thour_q;
    assign timer_nz_s = ({thour_q, tmin_q, tsec_q} != 24'h000000);
    // A tick is due on a prescaler wrap or when one was deferred by a write.
    assign due_s      = (~ctrl_q[CTRL_HALT] & (presc_q == PRESC_MAX)) | pend_q;

    // Next-state logic: prescaler, bus writes, and tick application.
    always_comb begin
        addr_d   = addr_q;   sec_d   = sec_q;   min_d   = min_q;
        hour_d   = hour_q;   day_d   = day_q;   month_d = month_q;
        year_d   = year_q;   tsec_d  = tsec_q;  tmin_d  = tmin_q;
        thour_d  = thour_q;  ctrl_d  = ctrl_q;  status_d = status_q;
        presc_d  = presc_q;  pend_d  = 1'b0;

        if (wr_data_stb && (addr_q == ADDR_SEC)) begin
            presc_d = {PW{1'b0}};
        end else if (ctrl_q[CTRL_HALT]) begin
            presc_d = presc_q;
        end else if (presc_q == PRESC_MAX) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1'b1);
        end

        if (wr_addr_stb) begin
            addr_d = data_s;
        end else begin
            addr_d = addr_q;
        end

        if (wr_data_stb) begin
            // The write wins this cycle; a coincident tick runs next cycle.
            pend_d = due_s;
            case (addr_q)
                ADDR_SEC:    sec_d    = data_s;
                ADDR_MIN:    min_d    = data_s;
                ADDR_HOUR:   hour_d   = data_s;
                ADDR_DAY:    day_d    = data_s;
                ADDR_MONTH:  month_d  = data_s;
                ADDR_YEAR:   year_d   = data_s;
                ADDR_TSEC:   tsec_d   = data_s;
                ADDR_TMIN:   tmin_d   = data_s;
                ADDR_THOUR:  thour_d  = data_s;
                ADDR_CTRL:   ctrl_d   = data_s[2:0];
                ADDR_STATUS: status_d = status_q & ~data_s[0];
                default:     status_d = status_q;
            endcase
        end else if (due_s) begin
            if (!ctrl_q[CTRL_HALT]) begin
                sec_d = bcd_inc(sec_q, 8'h00, 8'h59);
                if (c_sec)  min_d   = bcd_inc(min_q, 8'h00, 8'h59);
                else        min_d   = min_q;
                if (c_min)  hour_d  = bcd_inc(hour_q, 8'h00, 8'h23);
                else        hour_d  = hour_q;
                if (c_hour) day_d   = bcd_inc(day_q, 8'h01, dim_s);
                else        day_d   = day_q;
                if (c_day)  month_d = bcd_inc(month_q, 8'h01, 8'h12);
                else        month_d = month_q;
                if (c_mon)  year_d  = bcd_inc(year_q, 8'h00, 8'h99);
                else        year_d  = year_q;
            end else begin
                sec_d = sec_q;
            end
            if (ctrl_q[CTRL_TIMER_EN] && timer_nz_s) begin
                tsec_d  = tsec_n;
                tmin_d  = tmin_n;
                thour_d = thour_n;
                if ({thour_n, tmin_n, tsec_n} == 24'h000000) status_d = 1'b1;
                else                                         status_d = status_q;
            end else begin
                tsec_d = tsec_q;
            end
        end else begin
            pend_d = 1'b0;
        end
    end

    // Read mux for the register at addr_q; unmapped addresses read zero.
    always_comb begin
        rd_mux_s = 8'h00;
        case (addr_q)
            ADDR_SEC:    rd_mux_s = sec_q;
            ADDR_MIN:    rd_mux_s = min_q;
            ADDR_HOUR:   rd_mux_s = hour_q;
            ADDR_DAY:    rd_mux_s = day_q;
            ADDR_MONTH:  rd_mux_s = month_q;
            ADDR_YEAR:   rd_mux_s = year_q;
            ADDR_TSEC:   rd_mux_s = tsec_q;
            ADDR_TMIN:   rd_mux_s = tmin_q;
            ADDR_THOUR:  rd_mux_s = thour_q;
            ADDR_CTRL:   rd_mux_s = {5'd0, ctrl_q};
            ADDR_STATUS: rd_mux_s = {7'd0, status_q};
            default:     rd_mux_s = 8'h00;
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= 8'h00; sec_q  <= 8'h00; min_q   <= 8'h00; hour_q <= 8'h00;
            day_q   <= 8'h01; month_q <= 8'h01; year_q <= 8'h00;
            tsec_q  <= 8'h00; tmin_q <= 8'h00; thour_q <= 8'h00;
            ctrl_q  <= 3'd0;  status_q <= 1'b0; pend_q <= 1'b0;
            presc_q <= {PW{1'b0}};
            irq_q   <= 1'b0;  oe_q <= 1'b0; rdata_q <= 8'h00;
        end else begin
            addr_q  <= addr_d;  sec_q  <= sec_d;  min_q   <= min_d;  hour_q <= hour_d;
            day_q   <= day_d;   month_q <= month_d; year_q <= year_d;
            tsec_q  <= tsec_d;  tmin_q <= tmin_d; thour_q <= thour_d;
            ctrl_q  <= ctrl_d;  status_q <= status_d; pend_q <= pend_d;
            presc_q <= presc_d;
            irq_q   <= status_q & ctrl_q[CTRL_IRQ_EN];
            oe_q    <= rd_active;
            rdata_q <= rd_active ? rd_mux_s : 8'h00;
        end
    end

    assign bus.adata_o  = rdata_q;
    assign bus.adata_oe = oe_q;
    assign bus.IRQ      = irq_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with TICKS_PER_SEC = 16.
// Read expectations are queued when a read is issued and popped when the
// responder drives the bus.
module tb_rtc_bus_responder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rtc_bus_responder_if bus_if ();

    rtc_bus_responder #(.TICKS_PER_SEC(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One write phase: the register update lands on the 7th edge after the call.
    task automatic bus_phase(input logic ad, input logic [7:0] d);
        bus_if.AD = ad; bus_if.adata_i = d; bus_if.CS = 1'b0; bus_if.WR = 1'b0;
        cyc(4);
        bus_if.WR = 1'b1;
        cyc(4);
        bus_if.CS = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] d);
        bus_phase(1'b0, addr);
        bus_phase(1'b1, d);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] expv, input string tag);
        int n;
        logic [7:0] e;
        bus_phase(1'b0, addr);
        exp_q.push_back(expv);
        bus_if.AD = 1'b1; bus_if.CS = 1'b0; bus_if.RD = 1'b0;
        n = 0;
        while (bus_if.adata_oe !== 1'b1 && n < 12) begin
            cyc(1);
            n++;
        end
        e = exp_q.pop_front();
        check({tag, "_oe"}, {7'd0, bus_if.adata_oe}, 8'h01);
        check(tag, bus_if.adata_o, e);
        bus_if.RD = 1'b1;
        cyc(5);
        check({tag, "_release"}, {7'd0, bus_if.adata_oe}, 8'h00);
        bus_if.CS = 1'b1;
    endtask

    // From a halted state with the prescaler at 0: release halt, then halt
    // again after the first tick (edge +16) and before the second (edge +32).
    task automatic tick_once();
        bus_phase(1'b0, 8'h00);
        bus_phase(1'b1, 8'h00);
        cyc(12);
        bus_phase(1'b1, 8'h04);
    endtask

    initial begin
        reset = 1'b0;
        bus_if.AD = 1'b0; bus_if.CS = 1'b1; bus_if.RD = 1'b1; bus_if.WR = 1'b1;
        bus_if.adata_i = 8'h00;
        cyc(3);
        reset = 1'b1;
        cyc(1);

        // Reset state
        check("rst_oe", {7'd0, bus_if.adata_oe}, 8'h00);
        check("rst_adata", bus_if.adata_o, 8'h00);
        check("rst_irq", {7'd0, bus_if.IRQ}, 8'h00);
        wr_reg(8'h00, 8'h04);
        do_read(8'h00, 8'h04, "ctrl_halt");
        do_read(8'h01, 8'h00, "rst_status");
        do_read(8'h23, 8'h00, "rst_hour");
        do_read(8'h24, 8'h01, "rst_day");
        do_read(8'h25, 8'h01, "rst_month");
        do_read(8'h26, 8'h00, "rst_year");
        do_read(8'h41, 8'h00, "rst_tsec");

        // Write then read back, unmapped read
        wr_reg(8'h22, 8'h45);
        do_read(8'h22, 8'h45, "min_rb");
        do_read(8'h30, 8'h00, "unmapped");
        wr_reg(8'h30, 8'h77);
        do_read(8'h30, 8'h00, "unmapped_wr");

        // Full rollover
        wr_reg(8'h26, 8'h99); wr_reg(8'h25, 8'h12); wr_reg(8'h24, 8'h31);
        wr_reg(8'h23, 8'h23); wr_reg(8'h22, 8'h59); wr_reg(8'h21, 8'h59);
        tick_once();
        do_read(8'h21, 8'h00, "roll_sec");
        do_read(8'h22, 8'h00, "roll_min");
        do_read(8'h23, 8'h00, "roll_hour");
        do_read(8'h24, 8'h01, "roll_day");
        do_read(8'h25, 8'h01, "roll_month");
        do_read(8'h26, 8'h00, "roll_year");

        // Leap year February
        wr_reg(8'h26, 8'h24); wr_reg(8'h25, 8'h02); wr_reg(8'h24, 8'h28);
        wr_reg(8'h23, 8'h23); wr_reg(8'h22, 8'h59); wr_reg(8'h21, 8'h59);
        tick_once();
        do_read(8'h24, 8'h29, "leap_day");
        do_read(8'h25, 8'h02, "leap_month");
        // Non-leap February
        wr_reg(8'h26, 8'h23); wr_reg(8'h25, 8'h02); wr_reg(8'h24, 8'h28);
        wr_reg(8'h23, 8'h23); wr_reg(8'h22, 8'h59); wr_reg(8'h21, 8'h59);
        tick_once();
        do_read(8'h24, 8'h01, "feb_day");
        do_read(8'h25, 8'h03, "feb_month");

        // Tick/write collision: release at edge E (prescaler 0), the sec write
        // lands on E+16 together with the tick, then the deferred tick applies.
        wr_reg(8'h21, 8'h05);
        bus_phase(1'b0, 8'h00);
        bus_phase(1'b1, 8'h00);
        bus_phase(1'b0, 8'h21);
        bus_phase(1'b1, 8'h10);
        do_read(8'h21, 8'h11, "collision_sec");

        // Timer expiry
        wr_reg(8'h00, 8'h04);
        wr_reg(8'h43, 8'h00); wr_reg(8'h42, 8'h00); wr_reg(8'h41, 8'h02);
        wr_reg(8'h21, 8'h00);
        wr_reg(8'h00, 8'h03);
        cyc(20);
        check("irq_before", {7'd0, bus_if.IRQ}, 8'h00);
        cyc(20);
        check("irq_expired", {7'd0, bus_if.IRQ}, 8'h01);
        do_read(8'h01, 8'h01, "status_set");
        bus_phase(1'b1, 8'h01);
        cyc(3);
        check("irq_cleared", {7'd0, bus_if.IRQ}, 8'h00);
        do_read(8'h01, 8'h00, "status_clr");
        do_read(8'h41, 8'h00, "timer_sec");
        do_read(8'h42, 8'h00, "timer_min");
        do_read(8'h43, 8'h00, "timer_hour");

        // Reset in the middle of a read
        wr_reg(8'h00, 8'h04);
        wr_reg(8'h26, 8'h42);
        wr_reg(8'h41, 8'h07);
        bus_phase(1'b0, 8'h41);
        bus_if.AD = 1'b1; bus_if.CS = 1'b0; bus_if.RD = 1'b0;
        cyc(4);
        check("midread_oe", {7'd0, bus_if.adata_oe}, 8'h01);
        check("midread_data", bus_if.adata_o, 8'h07);
        reset = 1'b0;
        #1;
        check("reset_oe", {7'd0, bus_if.adata_oe}, 8'h00);
        check("reset_adata", bus_if.adata_o, 8'h00);
        bus_if.RD = 1'b1; bus_if.CS = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        wr_reg(8'h00, 8'h04);
        do_read(8'h41, 8'h00, "post_tsec");
        do_read(8'h26, 8'h00, "post_year");
        do_read(8'h25, 8'h01, "post_month");
        do_read(8'h24, 8'h01, "post_day");
        do_read(8'h22, 8'h00, "post_min");
        do_read(8'h01, 8'h00, "post_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Synthesizable model of the RTC chip on the multiplexed address/data bus, acting as the responder to the FPGA RTC controller. It decodes the address/data bus phases, holds a BCD register file (date, time, countdown timer, control and status), advances time once per second, and raises IRQ when the countdown timer expires. It is used for on-board loopback and simulation in place of the external RTC.

## Interface
- TICKS_PER_SEC, 100_000_000: clock cycles per RTC second; must be ≥ 16.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- AD  in  1  address/data phase select: 0 = address phase, 1 = data phase.
- CS  in  1  chip select, active low.
- RD  in  1  read strobe, active low.
- WR  in  1  write strobe, active low.
- adata_i  in  8  bus value from the pad.
- adata_o  out  8  read data driven to the pad.
- adata_oe  out  1  pad output enable. The top level builds the tri-state buffer.
- IRQ  out  1  interrupt, active high, level.

## Operation
- **Input sync.** AD, CS, RD, WR and adata_i pass through 2-flop synchronizers. All decoding uses the synchronized copies.
- **Address write.** On a synchronized WR rising edge with CS=0 and AD=0, store adata_i into addr_q (8 bits).
- **Data write.** On a synchronized WR rising edge with CS=0 and AD=1, write adata_i to the register at addr_q. Writes to unmapped addresses are dropped.
- **Read.** While CS=0, RD=0 and AD=1 (all synchronized), adata_oe=1 and adata_o = register at addr_q. Unmapped addresses read 0x00. Otherwise adata_oe=0 and adata_o=0x00.
- **Register map** (all BCD except control and status):
  - 0x21 sec
  - 0x22 min
  - 0x23 hour
  - 0x24 day
  - 0x25 month
  - 0x26 year
  - 0x41 timer sec
  - 0x42 timer min
  - 0x43 timer hour
  - 0x00 control: bit0 timer enable, bit1 IRQ enable, bit2 halt
  - 0x01 status: bit0 timer expired; write 1 to clear
- **Prescaler.** Counts 0..TICKS_PER_SEC-1. The cycle where it wraps produces a 1-cycle tick. Halt=1 freezes the prescaler and the clock registers. Any data write to 0x21 clears the prescaler.
- **Tick, clock.** sec increments from 59 to 00 and carries into min. min carries the same way into hour. hour goes 23 to 00 and carries into day. day wraps to 01 past the month length and carries into month. month goes 12 to 01 and carries into year. year goes 99 to 00.
  - Month length: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - February: 29 when the binary value of the BCD year is divisible by 4, else 28.
- **BCD increment.** A field ≥ its maximum wraps to its minimum and carries. A low nibble ≥9 goes to (tens+1),0.
- **Tick, timer.** Applies only when timer enable=1 and the timer is nonzero. The timer decrements through BCD borrow: sec 00→59 borrows from min, min 00→59 borrows from hour. When the timer becomes 00:00:00, set status bit0 and stop decrementing.
- **IRQ** = status bit0 & control bit1, registered.
- **Tick/write collision.** If a tick and a data write complete in the same cycle, the write is applied and the tick is held pending, then applied on the next cycle, after the write.
- **Status write.** A status write of 1 in the same cycle as expiry leaves the flag set.
- **Reset values:**
  - time 00:00:00, date day 01, month 01, year 00
  - timer 00:00:00
  - control 0x00, status 0x00, addr_q 0x00
  - prescaler 0, adata_o 0x00, adata_oe 0, IRQ 0

## Timing
- Synchronizer latency is 2 cycles; the edge detect adds 1.
- A register update is visible 3 cycles after WR rises at the pin.
- adata_oe asserts 3 cycles after the last of CS, RD, AD reaches the read condition, and deasserts 3 cycles after RD rises.
- adata_o is registered and valid in the same cycle adata_oe asserts.
- Requirements on the initiator:
  - hold adata_i and AD stable from WR falling until ≥4 cycles after WR rises;
  - keep strobes low for ≥4 cycles;
  - sample read data ≥4 cycles after RD falls.
- IRQ rises 1 cycle after status bit0 sets.
- An asynchronous reset mid-transfer aborts it. The bus is released immediately (adata_oe=0).

## Structure
- Shared package rtc_pkg holds:
  - the address constants (ADDR_SEC … ADDR_STATUS);
  - control bit indices;
  - the functions bcd_inc(value, min, max) and bcd_dec;
  - the function days_in_month(month, year).
- One sub-module, rtc_bus_sync: the 2-flop synchronizers plus the WR rising-edge and read-condition detection. Its outputs are wr_addr_stb, wr_data_stb, rd_active and data_s.

## Test plan
- **Write then read back.** Address 0x22, data 0x45, then read 0x22 → adata_oe=1 and adata_o=0x45. Read 0x30 → 0x00.
- **Full rollover.** TICKS_PER_SEC=16; set 99-12-31 23:59:59; 16 cycles → 00-01-01 00:00:00.
- **February and leap year.**
  - Year 0x24, month 02, day 28, 23:59:59, one tick → day 0x29.
  - Year 0x23, same time and date, one tick → month 03, day 01.
- **Timer expiry.** Timer 00:00:02, control 0x03; after 2 ticks → status 0x01, IRQ=1. Write 0x01 to 0x01 → IRQ=0 and the timer stays 00:00:00.
- **Collision.** Write sec=0x10 completing in the tick cycle → sec=0x10, then 0x11 the next cycle.
- **Reset mid-read.** Reset low while adata_oe=1 → adata_oe=0 immediately and all registers hold their reset values.
